// File: rtl/xilinx_sp_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xilinx_sp_bram_ctrl
// Purpose  : Valid/ready request initiator for a single-port BRAM with an
//            in-order, credit-protected read response FIFO.
//            Optional power-up zero sweep: SP_BRAM_CTRL_INIT_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xilinx_sp_bram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 4,
    parameter int DO_REG     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [WE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [14:0]           BRAM_ADDR,
    output logic                  BRAM_EN,
    output logic [7:0]            BRAM_WE,
    output logic [DATA_WIDTH-1:0] BRAM_DI,
    output logic                  BRAM_REGCE,
    output logic                  BRAM_RST,
    input  logic [DATA_WIDTH-1:0] BRAM_DO
);

    localparam int c_rd_lat = 1 + DO_REG;
    localparam int c_pw     = $clog2(FIFO_DEPTH);
    localparam int c_cw     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
`ifdef SP_BRAM_CTRL_INIT_CLEAR_EN
        ST_CLEAR = 2'd1,
`endif
        ST_RUN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_req_hs;
    logic                  w_rd_hs;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic [c_cw-1:0]       r_credit;
    logic [c_cw-1:0]       r_count;
    logic [c_pw-1:0]       r_wptr;
    logic [c_pw-1:0]       r_rptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_rd_lat-1:0]   r_lat;

    assign BRAM_REGCE = 1'b1;
    assign BRAM_RST   = 1'b0;

    // Credits count reads accepted but not yet consumed, so the FIFO can never overflow.
    assign req_ready = (r_state == ST_RUN) && (r_credit < c_cw'(FIFO_DEPTH));
    assign init_done = (r_state == ST_RUN);
    assign w_req_hs  = req_valid && req_ready;
    assign w_rd_hs   = w_req_hs && !req_we;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef SP_BRAM_CTRL_INIT_CLEAR_EN
    logic [ADDR_WIDTH-1:0] r_clr_addr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        BRAM_EN     = 1'b0;
        BRAM_WE     = 8'h00;
        BRAM_ADDR   = 15'h0000;
        BRAM_DI     = '0;
        case (r_state)
            ST_INIT: begin
`ifdef SP_BRAM_CTRL_INIT_CLEAR_EN
                w_state_nxt = ST_CLEAR;
`else
                w_state_nxt = ST_RUN;
`endif
            end
`ifdef SP_BRAM_CTRL_INIT_CLEAR_EN
            ST_CLEAR: begin
                BRAM_EN   = 1'b1;
                BRAM_WE   = 8'hFF;
                BRAM_ADDR = 15'(r_clr_addr);
                if (&r_clr_addr) begin
                    w_state_nxt = ST_RUN;
                end
            end
`endif
            ST_RUN: begin
                if (w_req_hs) begin
                    BRAM_EN   = 1'b1;
                    BRAM_ADDR = 15'(req_addr);
                    BRAM_DI   = req_wdata;
                    BRAM_WE   = req_we ? 8'(req_be) : 8'h00;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Read-valid pipe matches the BRAM read latency; its tail marks BRAM_DO as valid.
    if (c_rd_lat == 1) begin : g_lat_single
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_lat <= '0;
            end else begin
                r_lat <= w_rd_hs;
            end
        end
    end else begin : g_lat_multi
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_lat <= '0;
            end else begin
                r_lat <= {r_lat[c_rd_lat-2:0], w_rd_hs};
            end
        end
    end

    assign w_push    = r_lat[c_rd_lat-1];
    assign w_full    = (r_count == c_cw'(FIFO_DEPTH));
    assign rsp_valid = (r_count != '0);
    assign rsp_rdata = r_mem[r_rptr];
    assign w_pop     = rsp_valid && rsp_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_credit <= '0;
        end else begin
            case ({w_rd_hs, w_pop})
                2'b10:   r_credit <= r_credit + c_cw'(1);
                2'b01:   r_credit <= r_credit - c_cw'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= BRAM_DO;
                r_wptr        <= r_wptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_pw'(1);
            end
            r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(w_push && w_full && !w_pop))
        else $fatal(1, "xilinx_sp_bram_ctrl: response FIFO overflow");

endmodule
`default_nettype wire
